// File: rtl/mantissa_normalize_sequencer_if.sv
// Handshake bundle for the mantissa normalize sequencer.
// Producer side (in_*) and consumer side (out_*) share one interface.
interface mantissa_normalize_sequencer_if #(
  parameter int MANT_W  = 54,
  parameter int EXP_W   = 11,
  parameter int SHIFT_W = 6
);
  logic               in_valid;
  logic               in_ready;
  logic [MANT_W-1:0]  in_mantissa;
  logic [EXP_W-1:0]   in_exponent;
  logic               out_valid;
  logic               out_ready;
  logic [MANT_W-1:0]  out_mantissa;
  logic [EXP_W-1:0]   out_exponent;
  logic [SHIFT_W-1:0] out_shift;
  logic               out_zero;
  logic               out_underflow;
  logic               busy;

  modport master (
    output in_valid, in_mantissa, in_exponent, out_ready,
    input  in_ready, out_valid, out_mantissa, out_exponent,
    input  out_shift, out_zero, out_underflow, busy
  );

  modport slave (
    input  in_valid, in_mantissa, in_exponent, out_ready,
    output in_ready, out_valid, out_mantissa, out_exponent,
    output out_shift, out_zero, out_underflow, busy
  );
endinterface

// File: rtl/mantissa_normalize_sequencer.sv
// Iterative nibble normalizer: one 4-bit left shift per cycle.
// Define NORM_FINE_SHIFT_EN to add a final 0..3 bit fine shift.
module mantissa_normalize_sequencer #(
  parameter int MANT_W  = 54,
  parameter int EXP_W   = 11,
  parameter int SHIFT_W = 6
) (
  input logic clk,
  input logic rst,
  mantissa_normalize_sequencer_if.slave bus
);

`ifdef NORM_FINE_SHIFT_EN
  typedef enum logic [1:0] {
    S_IDLE, S_SHIFT, S_FINE, S_DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_SHIFT, S_DONE
  } state_t;
`endif

  state_t             r_state;
  logic [MANT_W-1:0]  r_mant;
  logic [EXP_W-1:0]   r_exp;
  logic [SHIFT_W-1:0] r_shift;
  logic               r_zero;
  logic               r_uf;
  logic               r_valid;

  logic [3:0] w_top;
  assign w_top = r_mant[MANT_W-1 -: 4];

`ifdef NORM_FINE_SHIFT_EN
  logic [1:0] w_lz;
  always_comb begin
    w_lz = 2'd3;
    unique case (1'b1)
      w_top[3]: w_lz = 2'd0;
      w_top[2]: w_lz = 2'd1;
      w_top[1]: w_lz = 2'd2;
      default:  w_lz = 2'd3;
    endcase
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mant  <= '0;
      r_exp   <= '0;
      r_shift <= '0;
      r_zero  <= 1'b0;
      r_uf    <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_shift <= '0;
            r_uf    <= 1'b0;
            if (bus.in_mantissa == '0) begin
              r_mant  <= '0;
              r_exp   <= '0;
              r_zero  <= 1'b1;
              r_valid <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_mant  <= bus.in_mantissa;
              r_exp   <= bus.in_exponent;
              r_zero  <= 1'b0;
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          if (w_top != 4'd0) begin
`ifdef NORM_FINE_SHIFT_EN
            r_state <= S_FINE;
`else
            r_valid <= 1'b1;
            r_state <= S_DONE;
`endif
          end else if (r_exp < EXP_W'(4)) begin
            // keep the partially normalized value
            r_uf    <= 1'b1;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_mant  <= {r_mant[MANT_W-5:0], 4'b0000};
            r_exp   <= r_exp - EXP_W'(4);
            r_shift <= r_shift + SHIFT_W'(4);
          end
        end
`ifdef NORM_FINE_SHIFT_EN
        S_FINE: begin
          if (r_exp >= EXP_W'(w_lz)) begin
            r_mant  <= r_mant << w_lz;
            r_exp   <= r_exp - EXP_W'(w_lz);
            r_shift <= r_shift + SHIFT_W'(w_lz);
          end else begin
            r_uf <= 1'b1;
          end
          r_valid <= 1'b1;
          r_state <= S_DONE;
        end
`endif
        S_DONE: begin
          if (bus.out_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready      = (r_state == S_IDLE) && !rst;
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.out_valid     = r_valid;
  assign bus.out_mantissa  = r_mant;
  assign bus.out_exponent  = r_exp;
  assign bus.out_shift     = r_shift;
  assign bus.out_zero      = r_zero;
  assign bus.out_underflow = r_uf;

endmodule

// File: tb/tb_mantissa_normalize_sequencer.sv
// Directed bench for the mantissa normalize sequencer.
// Expected results are hand-derived per operand.
module tb_mantissa_normalize_sequencer;
  localparam int MANT_W  = 54;
  localparam int EXP_W   = 11;
  localparam int SHIFT_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;

  mantissa_normalize_sequencer_if #(
    .MANT_W(MANT_W), .EXP_W(EXP_W), .SHIFT_W(SHIFT_W)
  ) bus ();

  mantissa_normalize_sequencer #(
    .MANT_W(MANT_W), .EXP_W(EXP_W), .SHIFT_W(SHIFT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_in(input logic [MANT_W-1:0] m,
                          input logic [EXP_W-1:0] e);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_mantissa = m;
    bus.in_exponent = e;
  endtask

  // Accept on the next edge, then count cycles until out_valid.
  task automatic accept_and_wait(input string tag, output int lat);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_out(input string tag, input int lat,
                           input int exp_lat,
                           input logic [MANT_W-1:0] em,
                           input logic [EXP_W-1:0] ee,
                           input logic [SHIFT_W-1:0] es,
                           input logic ez, input logic eu);
    @(negedge clk);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_mant"}, 64'(bus.out_mantissa), 64'(em));
    chk({tag, "_exp"}, 64'(bus.out_exponent), 64'(ee));
    chk({tag, "_shift"}, 64'(bus.out_shift), 64'(es));
    chk({tag, "_zero"}, 64'(bus.out_zero), 64'(ez));
    chk({tag, "_uf"}, 64'(bus.out_underflow), 64'(eu));
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_rel_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_rel_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  int lat;
  logic [MANT_W-1:0] hold_m;
  logic [EXP_W-1:0]  hold_e;

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_mantissa = '0;
    bus.in_exponent = '0;
    bus.out_ready   = 1'b0;

    #12;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mant", 64'(bus.out_mantissa), 64'd0);
    chk("rst_exp", 64'(bus.out_exponent), 64'd0);
    chk("rst_shift", 64'(bus.out_shift), 64'd0);
    chk("rst_flags", {62'd0, bus.out_zero, bus.out_underflow}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

    // already normalized
    drive_in(54'h20_0000_0000_0000, 11'd100);
    accept_and_wait("norm", lat);
`ifdef NORM_FINE_SHIFT_EN
    check_out("norm", lat, 3, 54'h20_0000_0000_0000, 11'd100, 6'd0, 0, 0);
`else
    check_out("norm", lat, 2, 54'h20_0000_0000_0000, 11'd100, 6'd0, 0, 0);
`endif
    release_out("norm");

    // worst case: 13 nibble shifts
    drive_in(54'h00_0000_0000_0001, 11'd1000);
    accept_and_wait("lsb", lat);
`ifdef NORM_FINE_SHIFT_EN
    check_out("lsb", lat, 16, 54'h20_0000_0000_0000, 11'd947, 6'd53, 0, 0);
`else
    check_out("lsb", lat, 15, 54'h10_0000_0000_0000, 11'd948, 6'd52, 0, 0);
`endif
    release_out("lsb");

    // zero operand
    drive_in(54'h0, 11'd500);
    accept_and_wait("zero", lat);
    check_out("zero", lat, 1, 54'h0, 11'd0, 6'd0, 1, 0);
    release_out("zero");

    // exponent floor
    drive_in(54'h00_0000_0000_00FF, 11'd9);
    accept_and_wait("uf", lat);
    check_out("uf", lat, 4, 54'h00_0000_0000_FF00, 11'd1, 6'd8, 0, 1);
    release_out("uf");

    // three shifts, then back-pressure in DONE
    drive_in(54'h00_0123_4567_89AB, 11'd50);
    accept_and_wait("bp", lat);
`ifdef NORM_FINE_SHIFT_EN
    check_out("bp", lat, 6, 54'h24_68AC_F135_6000, 11'd37, 6'd13, 0, 0);
`else
    check_out("bp", lat, 5, 54'h12_3456_789A_B000, 11'd38, 6'd12, 0, 0);
`endif
    hold_m = bus.out_mantissa;
    hold_e = bus.out_exponent;
    bus.in_valid    = 1'b1;
    bus.in_mantissa = 54'h0;
    bus.in_exponent = 11'd500;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_hold_mant", 64'(bus.out_mantissa), 64'(hold_m));
      chk("bp_hold_exp", 64'(bus.out_exponent), 64'(hold_e));
      chk("bp_hold_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_hold_zero", 64'(bus.out_zero), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("bp_rel_valid", 64'(bus.out_valid), 64'd0);
    chk("bp_rel_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    accept_and_wait("bp2", lat);
    check_out("bp2", lat, 1, 54'h0, 11'd0, 6'd0, 1, 0);
    release_out("bp2");

    // reset during the third shift
    drive_in(54'h00_0000_0000_0001, 11'd1000);
    accept_and_wait_short();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_ready", 64'(bus.in_ready), 64'd0);
    chk("mid_rst_mant", 64'(bus.out_mantissa), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
    drive_in(54'h00_0000_0000_00FF, 11'd9);
    accept_and_wait("post", lat);
    check_out("post", lat, 4, 54'h00_0000_0000_FF00, 11'd1, 6'd8, 0, 1);
    release_out("post");

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

  // Accept, then let three shift edges pass with no output yet.
  task automatic accept_and_wait_short();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", 64'(bus.busy), 64'd1);
    chk("mid_shift", 64'(bus.out_shift), 64'd12);
  endtask

endmodule
